// File: rtl/serial_adder.sv
// Serial adder: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Optional subtract mode (a + ~b + 1) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : gParamCheck
            $error("serial_adder: WIDTH must be >= 2 and an integer multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             carryReg;
    logic [CNT_W-1:0] chunkCnt;

    logic             lastChunk;
    int unsigned      shiftAmt;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK:0]   chunkRes;
    logic [WIDTH-1:0] bLoad;
    logic             carryLoad;

    // Operand B and initial carry as loaded on start (inverted B and forced carry when subtracting)
    always_comb begin
        bLoad     = b;
        carryLoad = c_in;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            bLoad     = ~b;
            carryLoad = 1'b1;
        end
`endif
    end

    // Current chunk slice and its sum with the running carry
    always_comb begin
        shiftAmt  = 32'(chunkCnt) * CHUNK;
        lastChunk = (chunkCnt == CNT_W'(NUM_CHUNKS - 1));
        aChunk    = CHUNK'(aReg >> shiftAmt);
        bChunk    = CHUNK'(bReg >> shiftAmt);
        chunkRes  = (CHUNK + 1)'(aChunk) + (CHUNK + 1)'(bChunk) + (CHUNK + 1)'(carryReg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (lastChunk) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and registered status; done trails the DONE state by one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            aReg     <= '0;
            bReg     <= '0;
            carryReg <= 1'b0;
            chunkCnt <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (stateNext == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg     <= a;
                        bReg     <= bLoad;
                        carryReg <= carryLoad;
                        chunkCnt <= '0;
                    end
                end
                RUN: begin
                    sum      <= (sum & ~(CHUNK_MASK << shiftAmt))
                              | (WIDTH'(chunkRes[CHUNK-1:0]) << shiftAmt);
                    carryReg <= chunkRes[CHUNK];
                    chunkCnt <= chunkCnt + CNT_W'(1);
                    if (lastChunk) begin
                        c_out <= chunkRes[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: bit-serial (CHUNK=1) and 4-bit-chunk instances
// driven with directed and random operands, compared against plain integer arithmetic.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       cIn;
    logic       sub;
    logic       busy1, done1, cOut1;
    logic       busy4, done4, cOut4;
    logic [7:0] sum1, sum4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a),
        .b     (b),
        .c_in  (cIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (cOut1)
    );

    serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a),
        .b     (b),
        .c_in  (cIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .c_out (cOut4)
    );

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: plain op; 1: extra start (a=AA) to dut1 while it runs; 2: reset during RUN
    task automatic doOp(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input int mode);
        logic [8:0] expVal;
        int busyCnt1 = 0, busyCnt4 = 0, doneCnt1 = 0, doneCnt4 = 0;
        int lat1 = -1, lat4 = -1;
        if (sv) expVal = 9'(av) + 9'(~bv) + 9'd1;
        else    expVal = 9'(av) + 9'(bv) + 9'(cv);
        a = av; b = bv; cIn = cv; sub = sv;
        start1 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cIn = 1'($urandom); sub = 1'($urandom);
        for (int n = 0; n <= 14; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (busy1) busyCnt1++;
            if (busy4) busyCnt4++;
            if (done1) begin doneCnt1++; if (lat1 < 0) lat1 = n; end
            if (done4) begin doneCnt4++; if (lat4 < 0) lat4 = n; end
            if (mode == 1 && n == 3) begin start1 = 1'b1; a = 8'hAA; end
            if (mode == 1 && n == 4) start1 = 1'b0;
            if (mode == 2 && n == 4) rst = 1'b1;
            if (mode == 2 && n == 5) begin
                checkVal("rst_busy", int'(busy1), 0);
                checkVal("rst_done", int'(done1), 0);
                checkVal("rst_sum", int'(sum1), 0);
                checkVal("rst_cout", int'(cOut1), 0);
                checkVal("rst_sum4", int'(sum4), 0);
                checkVal("rst_no_done", doneCnt1, 0);
                rst = 1'b0;
                return;
            end
        end
        checkVal("sum1", int'(sum1), int'(expVal[7:0]));
        checkVal("cout1", int'(cOut1), int'(expVal[8]));
        checkVal("sum4", int'(sum4), int'(expVal[7:0]));
        checkVal("cout4", int'(cOut4), int'(expVal[8]));
        checkVal("done_cnt1", doneCnt1, 1);
        checkVal("done_cnt4", doneCnt4, 1);
        checkVal("latency1", lat1, 9);
        checkVal("latency4", lat4, 3);
        checkVal("busy_cycles1", busyCnt1, 8);
        checkVal("busy_cycles4", busyCnt4, 2);
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        a = '0; b = '0; cIn = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_busy", int'(busy1), 0);
        checkVal("reset_done", int'(done1), 0);
        checkVal("reset_sum", int'(sum1), 0);
        checkVal("reset_cout", int'(cOut1), 0);
        checkVal("reset_sum4", int'(sum4), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        doOp(8'h05, 8'h03, 1'b0, 1'b0, 0);
        doOp(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        doOp(8'h00, 8'h00, 1'b1, 1'b0, 0);
        doOp(8'h9C, 8'h77, 1'b0, 1'b0, 0);
        doOp(8'h12, 8'h34, 1'b1, 1'b0, 1);
        doOp(8'h55, 8'h66, 1'b0, 1'b0, 2);
        doOp(8'h10, 8'h20, 1'b0, 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
        doOp(8'h05, 8'h03, 1'b0, 1'b1, 0);
        doOp(8'h03, 8'h05, 1'b1, 1'b1, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            logic sv;
`ifdef SERIAL_ADDER_SUB_EN
            sv = 1'($urandom);
`else
            sv = 1'b0;
`endif
            doOp(8'($urandom), 8'($urandom), 1'($urandom), sv, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits, minimum 2.
REQ-002 Parameter CHUNK, default 1: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; illegal values SHALL stop elaboration with an error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new addition; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A; captured on an accepted start.
REQ-007 b  input  WIDTH  operand B; captured on an accepted start.
REQ-008 c_in  input  1  carry-in; captured on an accepted start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when sum and c_out become valid.
REQ-011 sum  output  WIDTH  result, registered.
REQ-012 c_out  output  1  carry out of bit WIDTH-1, registered.

Function
REQ-013 Three states: IDLE, RUN, DONE; encoding is free, but the reset state SHALL be IDLE.
REQ-014 IDLE with start=1: latch a, b, c_in into internal registers, clear the chunk counter, go to RUN; busy=1 from the next cycle.
REQ-015 IDLE with start=0: remain in IDLE; outputs hold their values.
REQ-016 Each RUN cycle: add chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) of A and B plus the carry register, LSB chunk first; write the result into the same bit slice of sum; update the carry register with the chunk carry-out.
REQ-017 After chunk WIDTH/CHUNK-1 is processed: go to DONE; c_out is loaded with the final carry.
REQ-018 DONE: done=1, busy=0 for exactly one cycle, then IDLE.
REQ-019 Latency: start accepted at edge 0 -> done=1 in the cycle after edge WIDTH/CHUNK + 1; with WIDTH=8 and CHUNK=1 this is 9 edges after start; the next start may be accepted in the following cycle.
REQ-020 Result: {c_out, sum} SHALL equal a + b + c_in modulo 2^(WIDTH+1).
REQ-021 Result stability: sum and c_out hold the last result until the next accepted start; during RUN they hold partially updated values and are undefined to the user.
REQ-022 start during RUN or DONE: ignored; the operands in flight are unaffected, and the a, b and c_in inputs may change freely once start is accepted.

Reset
REQ-023 rst=1 at a clock edge: state=IDLE; busy, done, sum, c_out, the carry register and the chunk counter all 0.
REQ-024 Priority: rst SHALL override start and any in-progress operation.
REQ-025 Mid-operation reset: the aborted operation never asserts done.
REQ-026 Restart after reset: a start in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN: when defined, the block adds input port sub (1 bit), captured on an accepted start.
REQ-028 With SERIAL_ADDER_SUB_EN and sub=1: the block computes a - b as a + ~b + 1; c_in is ignored; c_out=1 means no borrow.
REQ-029 With SERIAL_ADDER_SUB_EN and sub=0: behaviour is identical to REQ-020.
REQ-030 Without SERIAL_ADDER_SUB_EN: the sub port and its logic are absent, and the block is addition only.

Verification
REQ-031 Basic add and latency (WIDTH=8, CHUNK=1): a=8'h05, b=8'h03, c_in=0, start pulse -> busy for 8 cycles, done one cycle, sum=8'h08, c_out=0.
REQ-032 Carry out and carry-in (WIDTH=8, CHUNK=1):
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1.
- a=8'h00, b=8'h00, c_in=1 -> sum=8'h01, c_out=0.
REQ-033 Start while busy: a second start at cycle 3 of RUN with a=8'hAA -> ignored; the first result is unchanged; exactly one done pulse.
REQ-034 Reset mid-operation: rst at cycle 4 of RUN -> all outputs 0, no done pulse; a new start next cycle with 8'h10+8'h20 -> sum=8'h30.
REQ-035 Multi-bit chunks (WIDTH=8, CHUNK=4): 8'h9C+8'h77 -> sum=8'h13, c_out=1, done 3 edges after start.
REQ-036 Subtract (SERIAL_ADDER_SUB_EN defined):
- 8'h05-8'h03 -> sum=8'h02, c_out=1.
- 8'h03-8'h05 -> sum=8'hFE, c_out=0.
